// File: rtl/atten_pkg.sv
// Shared definitions for the step-attenuator serial programming controllers.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package atten_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Every controller on a given attenuator bus runs from the same divider.
    localparam int DEFAULT_CLK_DIV = 20;

    // clog2 that never returns zero, so a count range of 1 still gets a 1-bit flop.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator for the attenuator serial clock.
// Latency: tick fires on the CLK_DIV-th enabled cycle after restart, then every CLK_DIV cycles.
// Backpressure: none; free-running while enable is high, cleared while idle or restarting.
//
// Ports: clk/reset_n (async active-low), restart clears the count and phase,
// enable runs the divider, tick marks the last cycle of a half period,
// phase is 0 in the low half and 1 in the high half.
module sclk_tick_gen
    import atten_pkg::*;
#(
    parameter  int CLK_DIV = DEFAULT_CLK_DIV,
    localparam int DIV_W   = clog2_min1(CLK_DIV)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic tick,
    output logic phase
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("sclk_tick_gen: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    assign tick  = enable && !restart && (cnt_q == CNT_LAST);
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart || !enable) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/serial_atten_ctrl.sv
// Serial programming controller: shifts one word onto a shared sclk/sdata bus, then pulses one latch enable.
// Latency: o_ready returns 1+2*DATA_W*CLK_DIV+CLK_DIV+2*LE_CYCLES*CLK_DIV cycles after acceptance.
// Backpressure: o_ready is high only in IDLE; i_valid is ignored while a transfer is in flight.
//
// Ports: i_clk, i_reset_n (async active-low); i_valid/o_ready request handshake with
// i_data/i_ch sampled at acceptance; o_sclk/o_sdata serial bus (registered);
// o_le one-hot per-channel latch enable; o_busy outside IDLE; o_err one-cycle
// pulse on a request for a channel that does not exist.
module serial_atten_ctrl
    import atten_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int NUM_CH    = 2,
    parameter  int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter  int MSB_FIRST = 0,
    parameter  int LE_CYCLES = 1,
    localparam int CH_W      = clog2_min1(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CH_W-1:0]   i_ch,
    output logic              o_sclk,
    output logic              o_sdata,
    output logic [NUM_CH-1:0] o_le,
    output logic              o_busy,
    output logic              o_err
);

    localparam int BIT_W = clog2_min1(DATA_W + 1);
    localparam int LE_W  = clog2_min1(2 * LE_CYCLES);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(2 * LE_CYCLES - 1);

    if (DATA_W < 1 || DATA_W > 32 || LE_CYCLES < 1 || CLK_DIV < 1 ||
        NUM_CH < 1 || NUM_CH > 16) begin : g_bad_param
        $error("serial_atten_ctrl: illegal parameter value");
    end

    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [LE_W-1:0]   le_cnt_q, le_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              sclk_q, sclk_d;
    logic [NUM_CH-1:0] le_q, le_d;
    logic              err_q, err_d;

    logic              tick;
    logic              phase;
    logic              accept;
    logic              ch_legal;
    logic              accept_ok;
    logic              bit_fall;
    logic              last_bit;
    logic              le_last;
    logic [DATA_W-1:0] data_rev;
    logic [DATA_W-1:0] load_word;

    assign accept    = (state_q == ST_IDLE) && i_valid;
    assign ch_legal  = 32'(i_ch) < NUM_CH;
    assign accept_ok = accept && ch_legal;
    // A tick in the high phase is the falling edge that ends the current bit.
    assign bit_fall  = tick && phase;
    assign last_bit  = (bit_q == BIT_LAST);
    assign le_last   = (le_cnt_q == LE_LAST);

    // The shifter always shifts right, so MSB-first words are bit-reversed on load.
    always_comb begin
        data_rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_rev[i] = i_data[DATA_W-1-i];
        end
    end

    assign load_word = (MSB_FIRST != 0) ? data_rev : i_data;

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .restart (accept),
        .enable  (state_q != ST_IDLE),
        .tick    (tick),
        .phase   (phase)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_ok)            state_d = ST_SHIFT;
            ST_SHIFT: if (bit_fall && last_bit) state_d = ST_GAP;
            ST_GAP:   if (tick)                 state_d = ST_LATCH;
            ST_LATCH: if (tick && le_last)      state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        bit_d    = bit_q;
        le_cnt_d = le_cnt_q;
        shreg_d  = shreg_q;
        ch_d     = ch_q;
        sclk_d   = 1'b0;
        le_d     = '0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_ok) begin
                    shreg_d = load_word;
                    bit_d   = '0;
                    ch_d    = i_ch;
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                sclk_d = tick ? ~phase : sclk_q;
                if (bit_fall) begin
                    if (last_bit) begin
                        // Clearing the shifter drives sdata low for the gap.
                        shreg_d = '0;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    le_d     = NUM_CH'(1) << ch_q;
                    le_cnt_d = '0;
                end
            end
            ST_LATCH: begin
                if (!(tick && le_last)) begin
                    le_d = le_q;
                    if (tick) begin
                        le_cnt_d = le_cnt_q + LE_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            le_cnt_q <= '0;
            shreg_q  <= '0;
            ch_q     <= '0;
            sclk_q   <= 1'b0;
            le_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            le_cnt_q <= le_cnt_d;
            shreg_q  <= shreg_d;
            ch_q     <= ch_d;
            sclk_q   <= sclk_d;
            le_q     <= le_d;
            err_q    <= err_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_busy  = (state_q != ST_IDLE);
    assign o_sclk  = sclk_q;
    assign o_sdata = shreg_q[0];
    assign o_le    = le_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_serial_atten_ctrl.sv
// Bench for serial_atten_ctrl: three parameter sets run side by side, each checked
// cycle by cycle against a waveform computed from the acceptance time and word.
// Latency: n/a. Backpressure: requests wait on o_ready.
module tb_serial_atten_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {sclk, sdata, le[15:0]} t cycles after an accepted request.
    function automatic logic [17:0] ref_wave(input int w, input int d, input bit msb,
                                             input logic [31:0] dat, input int c, input int t);
        int k;
        int idx;
        if (t <= 2 * w * d) begin
            k   = (t - 1) / (2 * d);
            idx = msb ? (w - 1 - k) : k;
            return {((t - 1) % (2 * d)) >= d, dat[idx], 16'h0};
        end
        if (t <= 2 * w * d + d) return 18'h0;
        return {2'b00, 16'h1 << c};
    endfunction

    localparam int          P_W   [3] = '{8, 6, 5};
    localparam int          P_D   [3] = '{20, 2, 1};
    localparam int          P_N   [3] = '{2, 3, 3};
    localparam int          P_MSB [3] = '{0, 1, 0};
    localparam int          P_LE  [3] = '{1, 1, 3};
    localparam logic [31:0] P_WORD[3] = '{32'hA5, 32'h32, 32'h15};
    localparam int          P_CH  [3] = '{1, 2, 2};

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W     = P_W[g];
        localparam int D     = P_D[g];
        localparam int N     = P_N[g];
        localparam int MSB   = P_MSB[g];
        localparam int LE    = P_LE[g];
        localparam int CW    = (N > 1) ? $clog2(N) : 1;
        localparam int TOTAL = 1 + 2 * W * D + D + 2 * LE * D;

        logic          rst_n;
        logic          valid;
        logic          ready;
        logic [W-1:0]  data;
        logic [CW-1:0] ch;
        logic          sclk;
        logic          sdata;
        logic [N-1:0]  le;
        logic          busy;
        logic          err;
        bit            done = 1'b0;

        serial_atten_ctrl #(
            .DATA_W    (W),
            .NUM_CH    (N),
            .CLK_DIV   (D),
            .MSB_FIRST (MSB),
            .LE_CYCLES (LE)
        ) u_dut (
            .i_clk     (clk),
            .i_reset_n (rst_n),
            .i_valid   (valid),
            .o_ready   (ready),
            .i_data    (data),
            .i_ch      (ch),
            .o_sclk    (sclk),
            .o_sdata   (sdata),
            .o_le      (le),
            .o_busy    (busy),
            .o_err     (err)
        );

        // Reference model state: transfer in flight, cycles since acceptance, captured request.
        bit          m_act  = 1'b0;
        int          m_t    = 0;
        logic [31:0] m_data = '0;
        int          m_ch   = 0;
        bit          m_err  = 1'b0;
        int          nrise  = 0;
        logic [31:0] cap    = '0;
        logic        prev_sclk = 1'b0;

        always @(negedge clk) begin
            logic [31:0] obs;
            logic [31:0] expv;
            logic [17:0] wave;
            bit          err_n;
            obs = {11'b0, ready, busy, err, sclk, sdata, 16'(le)};
            if (!rst_n) begin
                check($sformatf("reset%0d", g), obs, {11'b0, 1'b1, 20'b0});
                m_act = 1'b0; m_err = 1'b0; nrise = 0; cap = '0; prev_sclk = 1'b0;
            end else begin
                wave = m_act ? ref_wave(W, D, MSB != 0, m_data, m_ch, m_t) : 18'h0;
                expv = {11'b0, !m_act, m_act, m_err, wave};
                check($sformatf("wave%0d", g), obs, expv);
                // What the attenuator itself would latch: sdata sampled on each sclk rise.
                if (sclk && !prev_sclk) begin
                    if (nrise < W) cap[(MSB != 0) ? (W - 1 - nrise) : nrise] = sdata;
                    nrise++;
                end
                prev_sclk = sclk;
                if (m_act && m_t == 2 * W * D + D + 1) begin
                    check($sformatf("rises%0d", g), nrise, W);
                    check($sformatf("word%0d", g), cap, m_data);
                    nrise = 0; cap = '0;
                end
                err_n = 1'b0;
                if (m_act) begin
                    m_t++;
                    if (m_t == TOTAL) m_act = 1'b0;
                end else if (valid) begin
                    if (int'(ch) < N) begin
                        m_act = 1'b1; m_t = 1; m_data = 32'(data); m_ch = int'(ch);
                    end else begin
                        err_n = 1'b1;
                    end
                end
                m_err = err_n;
            end
        end

        task automatic send(input logic [31:0] d, input int c);
            int n;
            n = 0;
            while (!ready && n < 4 * TOTAL) begin
                @(posedge clk); #2; n++;
            end
            check($sformatf("ready_wait%0d", g), 32'(ready), 32'd1);
            valid = 1'b1; data = d[W-1:0]; ch = c[CW-1:0];
            @(posedge clk); #2;
            valid = 1'b0; data = W'($urandom); ch = CW'($urandom);
        endtask

        task automatic wait_ready(output int n);
            n = 0;
            while (!ready && n < 4 * TOTAL) begin
                @(posedge clk); #2; n++;
            end
        endtask

        initial begin
            int   n;
            int   rises;
            logic prev;
            rst_n = 1'b0; valid = 1'b0; data = '0; ch = '0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;

            send(P_WORD[g], P_CH[g]);
            wait_ready(n);
            check($sformatf("lat_dir%0d", g), n, TOTAL - 1);

            send(32'h0, (1 << CW) - 1);
            wait_ready(n);
            check($sformatf("lat_maxch%0d", g), n, (((1 << CW) - 1) < N) ? TOTAL - 1 : 0);

            // Reset in the same cycle as the 5th sclk rising edge.
            send($urandom, $urandom_range(0, N - 1));
            rises = 0; prev = sclk; n = 0;
            while (rises < 5 && n < 4 * TOTAL) begin
                @(posedge clk); #2; n++;
                if (sclk && !prev) rises++;
                prev = sclk;
            end
            check($sformatf("rise5_%0d", g), rises, 5);
            rst_n = 1'b0;
            #1;
            check($sformatf("async_rst%0d", g), {28'b0, sclk, |le, busy, ready}, 32'h1);
            @(posedge clk); @(posedge clk); #2;
            rst_n = 1'b1;
            send($urandom, $urandom_range(0, N - 1));
            wait_ready(n);
            check($sformatf("lat_post_rst%0d", g), n, TOTAL - 1);

            repeat (3) send($urandom, $urandom_range(0, (1 << CW) - 1));

            // Valid held through several ready windows with data changing every cycle.
            valid = 1'b1;
            repeat (3 * TOTAL + 5) begin
                data = W'($urandom); ch = CW'($urandom_range(0, N - 1));
                @(posedge clk); #2;
            end
            valid = 1'b0;
            wait_ready(n);
            repeat (5) @(posedge clk);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000; i++) begin
            if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
            @(posedge clk);
        end
        check("all_done", {29'b0, g_cfg[2].done, g_cfg[1].done, g_cfg[0].done}, 32'h7);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/serial_atten_ctrl.md
Name: serial_atten_ctrl

Overview:
Parametrised serial programming controller for step attenuators with a shared clock/data bus and per-channel latch enables. A valid/ready word request is shifted out DATA_W bits on o_sclk/o_sdata. The selected channel's o_le is then pulsed. Everything runs in the i_clk domain: o_sclk is a registered output, not a gated clock. The block sits between the register/control fabric and the attenuator pins, one instance per attenuator bus.

Parameters:
DATA_W, 8, attenuation word width in bits (1..32)
NUM_CH, 2, number of attenuators sharing sclk/sdata, one o_le each (1..16)
CLK_DIV, 20, i_clk cycles per o_sclk half-period (>=1)
MSB_FIRST, 0, 0 = bit 0 shifted first, 1 = bit DATA_W-1 first
LE_CYCLES, 1, o_le high time in whole o_sclk periods (>=1)

Ports:
i_clk  in  1  system clock, single clock domain
i_reset_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  high only in IDLE; transfer accepted on i_valid&&o_ready rising edge
i_data  in  DATA_W  attenuation word, sampled at acceptance
i_ch  in  CH_W  target channel, CH_W = max(1,clog2(NUM_CH)), sampled at acceptance
o_sclk  out  1  serial clock to attenuators, registered
o_sdata  out  1  serial data, changes only while o_sclk low
o_le  out  NUM_CH  latch enable, one-hot while active
o_busy  out  1  high in every state except IDLE
o_err  out  1  one-cycle pulse when an out-of-range channel is requested

Behaviour:
- Reset values: o_sclk=0, o_sdata=0, o_le=0, o_busy=0, o_err=0, state=IDLE, so o_ready=1.
- Reset is asynchronous in every register. Asserting it mid-transfer returns all outputs to reset values immediately. No partial word is ever latched.
- States:
  - IDLE -> SHIFT on acceptance with i_ch<NUM_CH.
  - SHIFT -> GAP after the last bit's high phase.
  - GAP -> LATCH after CLK_DIV cycles.
  - LATCH -> IDLE after 2*LE_CYCLES*CLK_DIV cycles.
- Acceptance with i_ch>=NUM_CH: o_err=1 for one cycle, state stays IDLE, no bus activity.
- The divider counter restarts at 0 on acceptance.
- Let T0 be the acceptance edge, D=CLK_DIV, W=DATA_W.
  - From T0+1: state SHIFT, o_sclk=0, o_sdata=first bit.
  - Bit k is driven for cycles [T0+1+2kD, T0+1+(2k+2)D). o_sclk is low for the first D cycles and high for the second D.
  - The next bit appears on the cycle o_sclk falls. The device samples on the rising edge.
  - Bit order: MSB_FIRST=0 gives i_data[0] first; MSB_FIRST=1 gives i_data[W-1] first.
- GAP: o_sclk=0 and o_sdata=0 for D cycles.
- LATCH: o_le[ch]=1 for 2*LE_CYCLES*D cycles, other o_le bits 0, o_sclk=0.
- o_ready returns to 1 at T0+1+2WD+D+2*LE_CYCLES*D.
  - With defaults (W=8, D=20, LE=1): T0+381.
  - Back-to-back requests are accepted on that cycle.
- i_valid while busy is ignored. i_data/i_ch changes after acceptance have no effect.
- o_sclk never glitches: exactly W rising edges per accepted transfer, none outside SHIFT.
- Bit counter width is clog2(DATA_W+1). Divider counter width is clog2(CLK_DIV).
- Illegal parameter values (CLK_DIV<1, LE_CYCLES<1, DATA_W outside 1..32) cause an elaboration-time error.

Decomposition:
- Shared package/header `atten_pkg`:
  - state encodings IDLE/SHIFT/GAP/LATCH (2 bits)
  - clog2-based width helper for CH_W and the counter widths
  - default CLK_DIV constant, shared with other controllers on the same bus
- One sub-module, `sclk_tick_gen`:
  - parameter CLK_DIV; inputs clk, reset_n, restart, enable
  - outputs half-period tick and phase (low/high)
  - the top FSM consumes the ticks

Test Plan:
- Defaults, i_data=8'hA5, i_ch=1, MSB_FIRST=0 -> 8 sclk rising edges sample bits 1,0,1,0,0,1,0,1; o_le=2'b10 for 40 cycles starting T0+341; o_ready=1 at T0+381; o_le[0] never asserts.
- MSB_FIRST=1, DATA_W=6, CLK_DIV=2, i_data=6'b110010 -> rising edges sample 1,1,0,0,1,0; o_sclk half-period exactly 2 cycles; o_ready=1 at T0+1+24+2+4=T0+31.
- NUM_CH=3, i_ch=3 -> o_err pulse exactly 1 cycle, o_ready stays 1, o_sclk/o_le stay 0; a following valid request to ch 2 completes normally.
- Reset asserted on the 5th sclk rising edge of a transfer -> same cycle: o_sclk=0, o_le=0, o_busy=0, o_ready=1; the next request shifts from bit 0 with full timing.
- i_valid held high continuously with changing i_data -> exactly one acceptance per o_ready window; each shifted word equals i_data at its acceptance cycle.
- CLK_DIV=1, LE_CYCLES=3 -> sclk toggles every cycle; o_le high for 6 cycles; no back-to-back acceptance gap beyond the o_ready cycle.
